div_seq: RTL

- Sequential unsigned restoring divider, N cycles per operation. It is the inverse-operation companion to the team's ripple-carry adder cells.
- The trial subtract is a WIDTH+1-bit ripple-borrow chain, computed as a + ~b + 1 using the same full-adder cell equations.
- Sits beside the adders in the combinational/sequential arithmetic library.
- Start/busy/done handshake to a controlling FSM.

---
 rtl/div_seq_if.sv | 26 ++
 rtl/div_seq.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: start/busy/done handshake and operand/result bus of div_seq.
//   master : drives start, dividend, divisor; observes the results.
//   slave  : the divider; drives quotient, remainder, busy, done, div_by_zero.
// Parameter WIDTH must match the WIDTH of the attached div_seq.
interface div_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : div_seq_if.slave
//           start/dividend/divisor in; quotient/remainder/busy/done/div_by_zero out
// Latency from the accepting edge E0: done is high in the cycle after
// E0+WIDTH, or after E0+1 for a zero divisor. Results and div_by_zero hold
// until the next completion (div_by_zero is cleared on accept).
// Optional macro DIV_SIGNED_EN: two's-complement operands, quotient
// truncated toward zero, remainder takes the dividend's sign.
module div_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    div_seq_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;      // partial remainder; always < divisor
    logic [WIDTH-1:0] r_dvd;      // dividend, shifted out MSB first
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_q;        // quotient bits collected so far
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem_out;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_b;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_quot_out;
    logic [WIDTH-1:0] w_rem_out;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;

    // Trial subtract as a ripple-borrow chain: shift + ~{0,divisor} + 1.
    // The top sum bit is set exactly when the subtraction borrows.
    always_comb begin
        logic c;
        w_shift = {r_rem, r_dvd[WIDTH-1]};
        w_b     = ~{1'b0, r_dvs};
        w_diff  = '0;
        c       = 1'b1;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            w_diff[i] = w_shift[i] ^ w_b[i] ^ c;
            c         = (w_shift[i] & w_b[i]) | (c & (w_shift[i] ^ w_b[i]));
        end
    end

    assign w_qbit   = ~w_diff[WIDTH];
    assign w_rem_nx = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_nx   = {r_q[WIDTH-2:0], w_qbit};

`ifdef DIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;

    // The most-negative value maps onto itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign w_dvd_mag  = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_dvs_mag  = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    assign w_quot_out = r_neg_q ? (~w_q_nx + 1'b1)   : w_q_nx;
    assign w_rem_out  = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if ((r_state == IDLE || r_state == DONE) && bus.start) begin
            r_neg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_r <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign w_dvd_mag  = bus.dividend;
    assign w_dvs_mag  = bus.divisor;
    assign w_quot_out = w_q_nx;
    assign w_rem_out  = w_rem_nx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_q       <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_dbz  <= 1'b0;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        r_rem  <= '0;
                        r_q    <= '0;
                        r_dvs  <= w_dvs_mag;
                        if (bus.divisor == '0) begin
                            // Raw dividend is kept: it becomes the remainder.
                            r_dvd   <= bus.dividend;
                            r_state <= ZERO;
                        end else begin
                            r_dvd   <= w_dvd_mag;
                            r_state <= RUN;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_quot    <= w_quot_out;
                        r_rem_out <= w_rem_out;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                ZERO: begin
                    r_quot    <= '1;
                    r_rem_out <= r_dvd;
                    r_dbz     <= 1'b1;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem_out;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule
